// File: rtl/hazard_dest_tracker_pkg.sv
// Shared definitions for the destination-register tracker: default widths,
// the slot record layout and the bubble value.
package hazard_dest_tracker_pkg;

    localparam int DEF_REG_ADDR_W = 5;
    localparam int DEF_CNT_W      = 16;

    // Slot record layout, MSB to LSB: {rd, rw, memRead}.
    localparam int SLOT_MR_BIT = 0;
    localparam int SLOT_RW_BIT = 1;
    localparam int SLOT_RD_LSB = 2;

    // Widest slot any instance may use; bounds the BUBBLE constant.
    localparam int SLOT_MAX_W = 32;

    // A bubble is the all-zero record: rd=x0, no write, not a load.
    localparam logic [SLOT_MAX_W-1:0] BUBBLE = '0;

    // Width of a full {rd, rw, memRead} record for a given register index width.
    function automatic int slot_w(input int reg_addr_w);
        return reg_addr_w + 2;
    endfunction

endpackage

// File: rtl/hazard_dest_tracker_dest_stage_reg.sv
// One pipeline slot register: async reset to bubble, hold while frozen,
// otherwise load either the incoming record or a bubble.
module dest_stage_reg
    import hazard_dest_tracker_pkg::*;
#(
    parameter int W = 7
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         hold,
    input  logic         bubble,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    // Slot state: reset and bubble both load the all-zero record; hold wins over bubble.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= BUBBLE[W-1:0];
        end else if (!hold) begin
            if (bubble) begin
                q <= BUBBLE[W-1:0];
            end else begin
                q <= d;
            end
        end
    end

endmodule

// File: rtl/hazard_dest_tracker.sv
// Producer side of the forwarding interface: tracks rd/rw of the EX, MEM and
// WB instructions, detects load-use hazards against EX, and drives the
// stall/flush controls for IF/ID and ID/EX.
module hazard_dest_tracker
    import hazard_dest_tracker_pkg::*;
#(
    parameter int REG_ADDR_W = DEF_REG_ADDR_W,
    parameter int CNT_W      = DEF_CNT_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  idValid,
    input  logic [REG_ADDR_W-1:0] idRd,
    input  logic                  idRw,
    input  logic                  idMemRead,
    input  logic [REG_ADDR_W-1:0] idRs1,
    input  logic [REG_ADDR_W-1:0] idRs2,
    input  logic                  idUsesRs1,
    input  logic                  idUsesRs2,
    input  logic                  branchTaken,
    input  logic                  memStall,
    output logic [REG_ADDR_W-1:0] idExRd,
    output logic                  idExRw,
    output logic [REG_ADDR_W-1:0] exMemRd,
    output logic                  exMemRw,
    output logic [REG_ADDR_W-1:0] memWBRd,
    output logic                  memWBRw,
    output logic                  stallIfId,
    output logic                  flushIfId,
    output logic                  flushIdEx,
    output logic [CNT_W-1:0]      bubbleCount
);

    // EX keeps the full record. Only EX is checked for load-use, so the load
    // flag is dropped once the instruction leaves EX: MEM and WB carry {rd, rw}.
    localparam int EX_W  = slot_w(REG_ADDR_W);
    localparam int TRK_W = REG_ADDR_W + 1;

    logic [EX_W-1:0]       ex_d;
    logic [EX_W-1:0]       ex_q;
    logic [TRK_W-1:0]      mem_q;
    logic [TRK_W-1:0]      wb_q;
    logic [REG_ADDR_W-1:0] ex_rd;
    logic                  ex_rw;
    logic                  ex_mr;
    logic                  rs1_hit;
    logic                  rs2_hit;
    logic                  load_use;
    logic                  hz;
    logic                  ex_bubble;
    logic [CNT_W-1:0]      bubble_cnt;

    assign ex_rd = ex_q[EX_W-1:SLOT_RD_LSB];
    assign ex_rw = ex_q[SLOT_RW_BIT];
    assign ex_mr = ex_q[SLOT_MR_BIT];

    // Hazard detection against the EX slot; a taken branch kills the ID
    // instruction so it never needs to stall.
    always_comb begin
        rs1_hit   = idUsesRs1 && (idRs1 == ex_rd);
        rs2_hit   = idUsesRs2 && (idRs2 == ex_rd);
        load_use  = idValid && ex_rw && ex_mr && (ex_rd != '0) && (rs1_hit || rs2_hit);
        hz        = load_use && !branchTaken;
        ex_bubble = hz || branchTaken || !idValid;
        // An x0 destination is never tracked as a write.
        ex_d      = {idRd, idRw && (idRd != '0), idMemRead};
    end

    // Stall/flush controls; all forced low while reset is asserted so no
    // pulse leaks out during or right after reset.
    always_comb begin
        stallIfId = !rst && (hz || memStall);
        flushIfId = !rst && branchTaken && !memStall;
        flushIdEx = !rst && (hz || branchTaken) && !memStall;
    end

    dest_stage_reg #(.W(EX_W)) u_ex (
        .clk    (clk),
        .rst    (rst),
        .hold   (memStall),
        .bubble (ex_bubble),
        .d      (ex_d),
        .q      (ex_q)
    );

    dest_stage_reg #(.W(TRK_W)) u_mem (
        .clk    (clk),
        .rst    (rst),
        .hold   (memStall),
        .bubble (1'b0),
        .d      (ex_q[EX_W-1:SLOT_RW_BIT]),
        .q      (mem_q)
    );

    dest_stage_reg #(.W(TRK_W)) u_wb (
        .clk    (clk),
        .rst    (rst),
        .hold   (memStall),
        .bubble (1'b0),
        .d      (mem_q),
        .q      (wb_q)
    );

    // Saturating count of load-use bubbles; frozen during a memory stall.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bubble_cnt <= '0;
        end else if (!memStall && hz && (bubble_cnt != '1)) begin
            bubble_cnt <= bubble_cnt + CNT_W'(1);
        end
    end

    assign idExRd      = ex_rd;
    assign idExRw      = ex_rw;
    assign exMemRd     = mem_q[TRK_W-1:1];
    assign exMemRw     = mem_q[0];
    assign memWBRd     = wb_q[TRK_W-1:1];
    assign memWBRw     = wb_q[0];
    assign bubbleCount = bubble_cnt;

endmodule

// File: tb/tb_hazard_dest_tracker.sv
// Directed bench for hazard_dest_tracker. A second instance with a 2-bit
// counter shares all inputs so counter saturation is reached in a few hazards.
module tb_hazard_dest_tracker;

    logic       clk;
    logic       rst;
    logic       idValid;
    logic [4:0] idRd;
    logic       idRw;
    logic       idMemRead;
    logic [4:0] idRs1;
    logic [4:0] idRs2;
    logic       idUsesRs1;
    logic       idUsesRs2;
    logic       branchTaken;
    logic       memStall;

    logic [4:0]  idExRd, exMemRd, memWBRd;
    logic        idExRw, exMemRw, memWBRw;
    logic        stallIfId, flushIfId, flushIdEx;
    logic [15:0] bubbleCount;

    logic [4:0]  s_idExRd, s_exMemRd, s_memWBRd;
    logic        s_idExRw, s_exMemRw, s_memWBRw;
    logic        s_stallIfId, s_flushIfId, s_flushIdEx;
    logic [1:0]  s_bubbleCount;

    int checks = 0;
    int errors = 0;

    hazard_dest_tracker dut (
        .clk(clk), .rst(rst), .idValid(idValid), .idRd(idRd), .idRw(idRw),
        .idMemRead(idMemRead), .idRs1(idRs1), .idRs2(idRs2),
        .idUsesRs1(idUsesRs1), .idUsesRs2(idUsesRs2),
        .branchTaken(branchTaken), .memStall(memStall),
        .idExRd(idExRd), .idExRw(idExRw), .exMemRd(exMemRd), .exMemRw(exMemRw),
        .memWBRd(memWBRd), .memWBRw(memWBRw), .stallIfId(stallIfId),
        .flushIfId(flushIfId), .flushIdEx(flushIdEx), .bubbleCount(bubbleCount)
    );

    hazard_dest_tracker #(.CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst), .idValid(idValid), .idRd(idRd), .idRw(idRw),
        .idMemRead(idMemRead), .idRs1(idRs1), .idRs2(idRs2),
        .idUsesRs1(idUsesRs1), .idUsesRs2(idUsesRs2),
        .branchTaken(branchTaken), .memStall(memStall),
        .idExRd(s_idExRd), .idExRw(s_idExRw), .exMemRd(s_exMemRd), .exMemRw(s_exMemRw),
        .memWBRd(s_memWBRd), .memWBRw(s_memWBRw), .stallIfId(s_stallIfId),
        .flushIfId(s_flushIfId), .flushIdEx(s_flushIdEx), .bubbleCount(s_bubbleCount)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(input logic [4:0] rd, input logic rw, input logic mr,
                          input logic [4:0] rs1, input logic u1,
                          input logic [4:0] rs2, input logic u2);
        idValid   = 1'b1;
        idRd      = rd;
        idRw      = rw;
        idMemRead = mr;
        idRs1     = rs1;
        idUsesRs1 = u1;
        idRs2     = rs2;
        idUsesRs2 = u2;
    endtask

    task automatic set_idle();
        idValid   = 1'b0;
        idRd      = '0;
        idRw      = 1'b0;
        idMemRead = 1'b0;
        idRs1     = '0;
        idUsesRs1 = 1'b0;
        idRs2     = '0;
        idUsesRs2 = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_idExRd"}, 32'(idExRd), 0);
        check({tag, "_idExRw"}, 32'(idExRw), 0);
        check({tag, "_exMemRd"}, 32'(exMemRd), 0);
        check({tag, "_exMemRw"}, 32'(exMemRw), 0);
        check({tag, "_memWBRd"}, 32'(memWBRd), 0);
        check({tag, "_memWBRw"}, 32'(memWBRw), 0);
        check({tag, "_stall"}, 32'(stallIfId), 0);
        check({tag, "_flushIfId"}, 32'(flushIfId), 0);
        check({tag, "_flushIdEx"}, 32'(flushIdEx), 0);
        check({tag, "_count"}, 32'(bubbleCount), 0);
    endtask

    initial begin
        // Reset
        rst = 1'b1;
        branchTaken = 1'b0;
        memStall = 1'b0;
        set_idle();
        #2;
        check_all_zero("rst_async");
        tick();
        tick();
        check_all_zero("rst");
        rst = 1'b0;

        // Load followed by dependent use
        set_id(5'd5, 1'b1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
        #1;
        check("lu_c0_stall", 32'(stallIfId), 0);
        tick();
        check("lu_ex_rd", 32'(idExRd), 5);
        check("lu_ex_rw", 32'(idExRw), 1);
        set_id(5'd6, 1'b1, 1'b0, 5'd5, 1'b1, 5'd0, 1'b0);
        #1;
        check("lu_stall", 32'(stallIfId), 1);
        check("lu_flushIdEx", 32'(flushIdEx), 1);
        check("lu_flushIfId", 32'(flushIfId), 0);
        tick();
        check("lu_bub_ex_rd", 32'(idExRd), 0);
        check("lu_bub_ex_rw", 32'(idExRw), 0);
        check("lu_mem_rd", 32'(exMemRd), 5);
        check("lu_mem_rw", 32'(exMemRw), 1);
        check("lu_count", 32'(bubbleCount), 1);
        #1;
        check("lu_stall_released", 32'(stallIfId), 0);
        check("lu_flushIdEx_released", 32'(flushIdEx), 0);
        tick();
        check("lu_ex_add", 32'(idExRd), 6);
        check("lu_mem_bubble", 32'(exMemRd), 0);
        check("lu_wb_rd", 32'(memWBRd), 5);

        // ALU chain: add x3 then sub using rs2=x3
        set_id(5'd3, 1'b1, 1'b0, 5'd1, 1'b1, 5'd2, 1'b1);
        #1;
        check("alu_stall0", 32'(stallIfId), 0);
        tick();
        set_id(5'd4, 1'b1, 1'b0, 5'd1, 1'b1, 5'd3, 1'b1);
        #1;
        check("alu_stall1", 32'(stallIfId), 0);
        tick();
        check("alu_mem_rd", 32'(exMemRd), 3);
        check("alu_mem_rw", 32'(exMemRw), 1);
        check("alu_ex_rd", 32'(idExRd), 4);
        set_idle();
        tick();
        check("alu_wb_rd", 32'(memWBRd), 3);
        check("alu_wb_rw", 32'(memWBRw), 1);
        check("alu_mem_rd2", 32'(exMemRd), 4);
        check("alu_ex_idle", 32'(idExRd), 0);

        // Writes to x0 are never tracked
        set_id(5'd0, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
        tick();
        check("x0_ex_rw", 32'(idExRw), 0);
        set_id(5'd7, 1'b1, 1'b0, 5'd0, 1'b1, 5'd0, 1'b0);
        #1;
        check("x0_stall", 32'(stallIfId), 0);
        tick();
        check("x0_mem_rw", 32'(exMemRw), 0);
        set_id(5'd0, 1'b1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
        tick();
        check("x0ld_ex_rw", 32'(idExRw), 0);
        set_id(5'd8, 1'b1, 1'b0, 5'd0, 1'b1, 5'd0, 1'b1);
        #1;
        check("x0ld_stall", 32'(stallIfId), 0);
        check("x0ld_flushIdEx", 32'(flushIdEx), 0);
        tick();
        check("x0ld_count", 32'(bubbleCount), 1);

        // Taken branch in the same cycle as a load-use hazard
        set_id(5'd9, 1'b1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
        tick();
        set_id(5'd10, 1'b1, 1'b0, 5'd0, 1'b0, 5'd9, 1'b1);
        branchTaken = 1'b1;
        #1;
        check("br_stall", 32'(stallIfId), 0);
        check("br_flushIfId", 32'(flushIfId), 1);
        check("br_flushIdEx", 32'(flushIdEx), 1);
        tick();
        branchTaken = 1'b0;
        set_idle();
        check("br_ex_rd", 32'(idExRd), 0);
        check("br_ex_rw", 32'(idExRw), 0);
        check("br_mem_rd", 32'(exMemRd), 9);
        check("br_count", 32'(bubbleCount), 1);

        // Memory stall freezes slots EX=7, MEM=6, WB=5
        set_id(5'd5, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
        tick();
        set_id(5'd6, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
        tick();
        set_id(5'd7, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
        tick();
        set_id(5'd11, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
        memStall = 1'b1;
        branchTaken = 1'b1;
        #1;
        check("ms_stall", 32'(stallIfId), 1);
        check("ms_flushIdEx", 32'(flushIdEx), 0);
        check("ms_flushIfId", 32'(flushIfId), 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("ms_hold_ex", 32'(idExRd), 7);
            check("ms_hold_mem", 32'(exMemRd), 6);
            check("ms_hold_wb", 32'(memWBRd), 5);
            check("ms_hold_stall", 32'(stallIfId), 1);
            check("ms_hold_flushIdEx", 32'(flushIdEx), 0);
        end
        memStall = 1'b0;
        branchTaken = 1'b0;
        set_idle();
        tick();
        check("ms_rel1_ex", 32'(idExRd), 0);
        check("ms_rel1_mem", 32'(exMemRd), 7);
        check("ms_rel1_wb", 32'(memWBRd), 6);
        tick();
        check("ms_rel2_mem", 32'(exMemRd), 0);
        check("ms_rel2_wb", 32'(memWBRd), 7);

        // Memory stall together with a load-use hazard
        set_id(5'd8, 1'b1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
        tick();
        set_id(5'd12, 1'b1, 1'b0, 5'd8, 1'b1, 5'd0, 1'b0);
        memStall = 1'b1;
        #1;
        check("mh_stall", 32'(stallIfId), 1);
        check("mh_flushIdEx", 32'(flushIdEx), 0);
        tick();
        check("mh_ex_hold", 32'(idExRd), 8);
        check("mh_count_hold", 32'(bubbleCount), 1);
        memStall = 1'b0;
        #1;
        check("mh_stall_after", 32'(stallIfId), 1);
        check("mh_flushIdEx_after", 32'(flushIdEx), 1);
        tick();
        check("mh_ex_bubble", 32'(idExRd), 0);
        check("mh_count", 32'(bubbleCount), 2);

        // Asynchronous reset in the middle of a memory stall
        set_id(5'd13, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
        tick();
        memStall = 1'b1;
        branchTaken = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        check_all_zero("arst");
        memStall = 1'b0;
        branchTaken = 1'b0;
        set_idle();
        #2;
        rst = 1'b0;
        #1;
        check_all_zero("arst_rel");
        check("arst_sat_count", 32'(s_bubbleCount), 0);

        // Counter saturation on the 2-bit instance
        for (int i = 0; i < 4; i++) begin
            set_id(5'd5, 1'b1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
            tick();
            set_id(5'd6, 1'b1, 1'b0, 5'd5, 1'b1, 5'd0, 1'b0);
            #1;
            check("sat_stall", 32'(s_stallIfId), 1);
            tick();
            check("sat_count", 32'(s_bubbleCount), (i < 3) ? 32'(i + 1) : 32'd3);
        end
        check("sat_main_count", 32'(bubbleCount), 4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/hazard_dest_tracker.md
Name: hazard_dest_tracker

Overview:
- Producer side of the forwarding-unit interface for the 5-stage core.
- Tracks the destination register, register-write flag and load flag of the instructions in EX, MEM and WB.
- Drives exMemRd/exMemRw/memWBRd/memWBRw to the forwarding unit.
- Detects load-use hazards, inserts bubbles, applies branch flushes and freezes on data-memory stalls.

Parameters:
- REG_ADDR_W, 5, register index width.
- CNT_W, 16, width of saturating bubble counter.

Ports:
- clk  input  1  core clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- idValid  input  1  ID stage holds a real instruction.
- idRd  input  REG_ADDR_W  destination of ID instruction.
- idRw  input  1  ID instruction writes rd.
- idMemRead  input  1  ID instruction is a load.
- idRs1  input  REG_ADDR_W  source 1 of ID instruction.
- idRs2  input  REG_ADDR_W  source 2 of ID instruction.
- idUsesRs1  input  1  rs1 is actually read.
- idUsesRs2  input  1  rs2 is actually read.
- branchTaken  input  1  EX resolved a taken branch/jump this cycle.
- memStall  input  1  data memory not ready; freeze whole pipeline.
- idExRd  output  REG_ADDR_W  EX-slot destination.
- idExRw  output  1  EX-slot writes rd.
- exMemRd  output  REG_ADDR_W  MEM-slot destination (to forwarding).
- exMemRw  output  1  MEM-slot writes rd.
- memWBRd  output  REG_ADDR_W  WB-slot destination.
- memWBRw  output  1  WB-slot writes rd.
- stallIfId  output  1  hold PC and IF/ID register.
- flushIfId  output  1  clear IF/ID register.
- flushIdEx  output  1  insert bubble into ID/EX.
- bubbleCount  output  CNT_W  load-use bubbles inserted since reset.

Behaviour:
- Each slot (EX, MEM, WB) holds {rd, rw, memRead}.
- Bubble value is all-zero.
- Reset (async): all slots become bubble, bubbleCount=0, and all outputs are 0.
- Load-use hazard: loadUse = idValid & exRw & exMemRead & (exRd!=0) & ((idUsesRs1 & idRs1==exRd) | (idUsesRs2 & idRs2==exRd)).
  - Only the EX slot is checked; MEM and WB are covered by forwarding.
- Effective hazard: hz = loadUse & ~branchTaken. A taken branch kills the ID instruction, so no stall is needed.
- Combinational outputs:
  - stallIfId = hz | memStall.
  - flushIfId = branchTaken & ~memStall.
  - flushIdEx = (hz | branchTaken) & ~memStall.
- Rising edge with memStall=1: every slot and bubbleCount hold. No flush takes effect.
- Rising edge with memStall=0:
  - WB <= MEM; MEM <= EX.
  - EX <= bubble if hz | branchTaken | ~idValid.
  - Otherwise EX <= {idRd, idRw & (idRd!=0), idMemRead}. An x0 write is never tracked as rw=1.
  - bubbleCount increments by 1 when hz=1 and saturates at all-ones.
- Slot outputs are registered values. Latency is exactly 1 cycle per stage: an ID instruction reaches exMemRd 2 edges later and memWBRd 3 edges later (no stalls).
- Simultaneous memStall and hazard: stallIfId=1, no bubble inserted, no count. The hazard is re-evaluated after the freeze ends.
- A load-use stall lasts exactly one cycle, because the load moves to MEM on the next edge.
- Reset asserted mid-operation clears pending bubbles and hazards immediately. No flush pulse is emitted after release.

Decomposition:
- Shared package/header holds:
  - REG_ADDR_W default.
  - Slot record layout {rd, rw, memRead} and its width.
  - BUBBLE constant (all zero).
- One natural sub-module: dest_stage_reg.
  - One slot register with async reset, a hold (enable) input and a bubble-insert input.
  - Instantiated three times.

Test Plan:
- Load then dependent use: cycle0 ID lw x5 (rd=5, memRead=1, rw=1); cycle1 ID add rs1=5.
  - Required in cycle1: stallIfId=1, flushIdEx=1.
  - Next edge: idExRd=0, exMemRd=5, bubbleCount=1.
  - Following cycle: stallIfId=0.
- ALU chain: add x3 followed by sub rs2=3, no load.
  - stallIfId stays 0.
  - exMemRd=3, exMemRw=1 two edges after issue.
  - memWBRd=3 one edge later.
- Write to x0: idRd=0, idRw=1, followed by a use of rs1=0.
  - Slots show rw=0 and no stall occurs.
  - Same with idMemRead=1: still no stall.
- Branch with hazard: load in EX, ID uses rd, branchTaken=1 in the same cycle.
  - stallIfId=0, flushIfId=1, flushIdEx=1.
  - bubbleCount unchanged.
  - EX slot becomes bubble.
- memStall=1 for 3 cycles with slots EX=7, MEM=6, WB=5.
  - All slots hold and stallIfId=1 throughout.
  - flushIdEx=0 even if branchTaken=1.
  - After release, slots advance one per edge.
- Reset asserted asynchronously mid-stall (no clock edge).
  - All outputs read 0 immediately.
  - bubbleCount=0 after release.
  - Counter saturation: force count to 16'hFFFF, apply a hazard, count stays 16'hFFFF.
